// File: rtl/branch_bimodal_ctrl.sv
// Bimodal predictor control: arbitrates the single datapath PC port between
// fetch-side lookups and buffered execute-side counter updates.
module branch_bimodal_ctrl #(
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req_val,
    output logic        pred_req_rdy,
    input  logic [31:0] pred_req_pc,
    output logic        pred_resp_val,
    input  logic        pred_resp_rdy,
    output logic        pred_resp_taken,
    input  logic        upd_req_val,
    output logic        upd_req_rdy,
    input  logic [31:0] upd_req_pc,
    input  logic        upd_req_taken,
    input  logic        upd_req_pred,
    output logic [31:0] dp_pc,
    input  logic        dp_prediction,
    input  logic        dp_upper_reached,
    input  logic        dp_lower_reached,
    output logic        dp_increment_entry,
    output logic        dp_decrement_entry,
    output logic [15:0] mispred_count
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

    typedef enum logic [1:0] {GntNone, GntPred, GntUpd} grant_e;

    upd_entry_t      fifo_q [QUEUE_DEPTH];
    upd_entry_t      fifo_d [QUEUE_DEPTH];
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            resp_val_q, resp_val_d;
    logic            resp_taken_q, resp_taken_d;
    logic [15:0]     mispred_q, mispred_d;

    grant_e          grant;
    upd_entry_t      head;
    logic            fifo_empty, fifo_full;
    logic            pred_elig, upd_elig;
    logic            push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        pred_elig = pred_req_val && (!resp_val_q || pred_resp_rdy);
        upd_elig  = !fifo_empty;

        grant = GntNone;
        if (reset) begin
            if (upd_elig && (!pred_elig || starve_q == STARVE_MAX)) begin
                grant = GntUpd;
            end else if (pred_elig) begin
                grant = GntPred;
            end
        end
    end

    always_comb begin
        pred_req_rdy       = (grant == GntPred);
        upd_req_rdy        = reset && !fifo_full;
        pred_resp_val      = reset && resp_val_q;
        pred_resp_taken    = resp_taken_q;
        mispred_count      = mispred_q;

        dp_pc = pred_req_pc;
        if (grant != GntPred && upd_elig) begin
            dp_pc = head.pc;
        end
        dp_increment_entry = (grant == GntUpd) && head.taken && !dp_upper_reached;
        dp_decrement_entry = (grant == GntUpd) && !head.taken && !dp_lower_reached;
    end

    always_comb begin
        push = upd_req_val && upd_req_rdy;
        pop  = (grant == GntUpd);

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[PW-1:0]] = '{pc: upd_req_pc, taken: upd_req_taken};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        starve_d = starve_q;
        if (!upd_elig || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end

        resp_val_d   = resp_val_q;
        resp_taken_d = resp_taken_q;
        if (grant == GntPred) begin
            resp_val_d   = 1'b1;
            resp_taken_d = dp_prediction;
        end else if (pred_resp_rdy) begin
            resp_val_d = 1'b0;
        end

        mispred_d = mispred_q;
        if (push && (upd_req_taken != upd_req_pred) && (mispred_q != 16'hFFFF)) begin
            mispred_d = mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_q     <= '0;
            resp_val_q   <= 1'b0;
            resp_taken_q <= 1'b0;
            mispred_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_q     <= starve_d;
            resp_val_q   <= resp_val_d;
            resp_taken_q <= resp_taken_d;
            mispred_q    <= mispred_d;
        end
    end

endmodule

// File: tb/tb_branch_bimodal_ctrl.sv
// Directed bench for branch_bimodal_ctrl with a small 2-bit counter table
// standing in for the predictor datapath.
module tb_branch_bimodal_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_req_val = 1'b0;
    logic        pred_req_rdy;
    logic [31:0] pred_req_pc = '0;
    logic        pred_resp_val;
    logic        pred_resp_rdy = 1'b0;
    logic        pred_resp_taken;
    logic        upd_req_val = 1'b0;
    logic        upd_req_rdy;
    logic [31:0] upd_req_pc = '0;
    logic        upd_req_taken = 1'b0;
    logic        upd_req_pred = 1'b0;
    logic [31:0] dp_pc;
    logic        dp_prediction;
    logic        dp_upper_reached;
    logic        dp_lower_reached;
    logic        dp_increment_entry;
    logic        dp_decrement_entry;
    logic [15:0] mispred_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_bimodal_ctrl #(
        .QUEUE_DEPTH (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pred_req_val      (pred_req_val),
        .pred_req_rdy      (pred_req_rdy),
        .pred_req_pc       (pred_req_pc),
        .pred_resp_val     (pred_resp_val),
        .pred_resp_rdy     (pred_resp_rdy),
        .pred_resp_taken   (pred_resp_taken),
        .upd_req_val       (upd_req_val),
        .upd_req_rdy       (upd_req_rdy),
        .upd_req_pc        (upd_req_pc),
        .upd_req_taken     (upd_req_taken),
        .upd_req_pred      (upd_req_pred),
        .dp_pc             (dp_pc),
        .dp_prediction     (dp_prediction),
        .dp_upper_reached  (dp_upper_reached),
        .dp_lower_reached  (dp_lower_reached),
        .dp_increment_entry(dp_increment_entry),
        .dp_decrement_entry(dp_decrement_entry),
        .mispred_count     (mispred_count)
    );

    always #5 clk = ~clk;

    // Datapath model: 16 counters indexed by dp_pc[11:8].
    logic [1:0] pht [16];
    logic [3:0] idx;
    logic       load_en = 1'b0;
    logic [3:0] load_idx = '0;
    logic [1:0] load_val = '0;

    assign idx              = dp_pc[11:8];
    assign dp_prediction    = pht[idx][1];
    assign dp_upper_reached = (pht[idx] == 2'd3);
    assign dp_lower_reached = (pht[idx] == 2'd0);

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) pht[i] <= 2'd0;
        end else if (load_en) begin
            pht[load_idx] <= load_val;
        end else if (dp_increment_entry) begin
            pht[idx] <= pht[idx] + 2'd1;
        end else if (dp_decrement_entry) begin
            pht[idx] <= pht[idx] - 2'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] i, input logic [1:0] v);
        tick();
        load_en  = 1'b1;
        load_idx = i;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    typedef struct {
        logic        pv;
        logic        rr;
        logic [31:0] pc;
        logic        e_rdy;
        logic        e_val;
        logic        e_taken;
    } pvec_t;

    pvec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          grants;
        int          resps;
        logic [5:0]  exp_inc;
        logic [5:0]  exp_dec;
        logic [31:0] pcs [4];
        logic [3:0]  tk;

        tbl[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0};

        // Reset hold with every valid high.
        reset         = 1'b0;
        pred_req_val  = 1'b1;
        upd_req_val   = 1'b1;
        pred_resp_rdy = 1'b1;
        pred_req_pc   = 32'h100;
        upd_req_pc    = 32'h200;
        upd_req_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("rst_pred_req_rdy", pred_req_rdy, 0);
            check("rst_upd_req_rdy", upd_req_rdy, 0);
            check("rst_pred_resp_val", pred_resp_val, 0);
            check("rst_inc", dp_increment_entry, 0);
            check("rst_dec", dp_decrement_entry, 0);
            check("rst_mispred", mispred_count, 0);
        end
        tick();
        reset        = 1'b1;
        pred_req_val = 1'b0;
        upd_req_val  = 1'b0;
        pred_req_pc  = 32'hABC0;
        #1;
        check("post_rst_upd_rdy", upd_req_rdy, 1);
        check("post_rst_dp_pc", dp_pc, 32'hABC0);
        check("post_rst_resp_val", pred_resp_val, 0);

        // Predict latency and backpressure hold.
        load(4'd1, 2'd2);
        for (int i = 0; i < 6; i++) begin
            tick();
            pred_req_val  = tbl[i].pv;
            pred_resp_rdy = tbl[i].rr;
            pred_req_pc   = tbl[i].pc;
            #1;
            check($sformatf("pv%0d_req_rdy", i), pred_req_rdy, tbl[i].e_rdy);
            check($sformatf("pv%0d_resp_val", i), pred_resp_val, tbl[i].e_val);
            check($sformatf("pv%0d_dp_pc", i), dp_pc, tbl[i].pc);
            if (tbl[i].e_val) check($sformatf("pv%0d_taken", i), pred_resp_taken, tbl[i].e_taken);
        end

        // Back-to-back throughput.
        grants = 0;
        resps  = 0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            pred_req_val  = (i < 10);
            pred_req_pc   = 32'h100;
            pred_resp_rdy = 1'b1;
            #1;
            if (pred_req_rdy) grants++;
            if (pred_resp_val) begin
                resps++;
                check("b2b_taken", pred_resp_taken, 1);
            end
        end
        check("b2b_grants", grants, 10);
        check("b2b_resps", resps, 10);
        tick();
        #1;
        check("b2b_drained", pred_resp_val, 0);

        // Saturation up then down on PC 0x200.
        exp_inc = 6'b001110;
        for (int c = 0; c < 6; c++) begin
            tick();
            pred_req_val  = 1'b0;
            upd_req_val   = (c < 4);
            upd_req_pc    = 32'h200;
            upd_req_taken = 1'b1;
            upd_req_pred  = 1'b1;
            #1;
            check($sformatf("sat_up%0d_inc", c), dp_increment_entry, exp_inc[c]);
            check($sformatf("sat_up%0d_dec", c), dp_decrement_entry, 0);
            if (exp_inc[c]) check("sat_up_dp_pc", dp_pc, 32'h200);
        end
        check("sat_up_counter", pht[2], 3);
        exp_dec = 6'b001110;
        for (int c = 0; c < 6; c++) begin
            tick();
            upd_req_val   = (c < 4);
            upd_req_taken = 1'b0;
            upd_req_pred  = 1'b0;
            #1;
            check($sformatf("sat_dn%0d_dec", c), dp_decrement_entry, exp_dec[c]);
            check($sformatf("sat_dn%0d_inc", c), dp_increment_entry, 0);
        end
        check("sat_dn_counter", pht[2], 0);
        check("sat_mispred", mispred_count, 0);

        // Starvation: one update behind a continuous prediction stream.
        tick();
        pred_req_val  = 1'b1;
        pred_req_pc   = 32'h100;
        pred_resp_rdy = 1'b1;
        upd_req_val   = 1'b1;
        upd_req_pc    = 32'h400;
        upd_req_taken = 1'b1;
        upd_req_pred  = 1'b1;
        #1;
        check("stv_push_rdy", upd_req_rdy, 1);
        check("stv_c0_req_rdy", pred_req_rdy, 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            upd_req_val = 1'b0;
            #1;
            check($sformatf("stv_c%0d_req_rdy", c), pred_req_rdy, (c != 9));
            if (c == 9) begin
                check("stv_inc", dp_increment_entry, 1);
                check("stv_dp_pc", dp_pc, 32'h400);
            end
        end
        tick();
        pred_req_val = 1'b0;

        // FIFO full and mispredict counting, then in-order drain.
        load(4'd6, 2'd2);
        load(4'd8, 2'd3);
        pcs[0] = 32'h500;
        pcs[1] = 32'h600;
        pcs[2] = 32'h700;
        pcs[3] = 32'h800;
        tk     = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            tick();
            pred_req_val  = 1'b1;
            pred_req_pc   = 32'h100;
            pred_resp_rdy = 1'b1;
            upd_req_val   = 1'b1;
            upd_req_pc    = (c < 4) ? pcs[c] : 32'hF00;
            upd_req_taken = (c < 4) ? tk[c] : 1'b1;
            upd_req_pred  = !upd_req_taken;
            #1;
            check($sformatf("full_c%0d_upd_rdy", c), upd_req_rdy, (c < 4));
            check($sformatf("full_c%0d_inc", c), dp_increment_entry, 0);
            check($sformatf("full_c%0d_dec", c), dp_decrement_entry, 0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            pred_req_val = 1'b0;
            upd_req_val  = 1'b0;
            #1;
            check($sformatf("drain%0d_dp_pc", k), dp_pc, pcs[k]);
            check($sformatf("drain%0d_inc", k), dp_increment_entry, tk[k]);
            check($sformatf("drain%0d_dec", k), dp_decrement_entry, !tk[k]);
            if (k == 0) begin
                check("drain_full_rdy", upd_req_rdy, 0);
                check("drain_mispred", mispred_count, 4);
            end
            if (k == 1) check("drain_rdy_back", upd_req_rdy, 1);
        end
        tick();
        #1;
        check("drain_empty_inc", dp_increment_entry, 0);
        check("drain_empty_dec", dp_decrement_entry, 0);
        check("drain_final_mispred", mispred_count, 4);

        // Reset mid-operation discards queued updates and the pending response.
        for (int c = 0; c < 2; c++) begin
            tick();
            pred_req_val  = 1'b1;
            pred_req_pc   = 32'h100;
            upd_req_val   = 1'b1;
            upd_req_pc    = 32'h900;
            upd_req_taken = 1'b1;
            upd_req_pred  = 1'b0;
            #1;
            check($sformatf("mid_c%0d_mispred", c), mispred_count, 4 + c);
        end
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_req_rdy", pred_req_rdy, 0);
        check("mid_rst_upd_rdy", upd_req_rdy, 0);
        check("mid_rst_resp_val", pred_resp_val, 0);
        check("mid_rst_inc", dp_increment_entry, 0);
        check("mid_rst_mispred_pre", mispred_count, 6);
        tick();
        reset        = 1'b1;
        pred_req_val = 1'b0;
        upd_req_val  = 1'b0;
        pred_req_pc  = 32'h1234;
        #1;
        check("mid_post_mispred", mispred_count, 0);
        check("mid_post_resp_val", pred_resp_val, 0);
        check("mid_post_upd_rdy", upd_req_rdy, 1);
        check("mid_post_dp_pc", dp_pc, 32'h1234);
        check("mid_post_inc", dp_increment_entry, 0);
        check("mid_post_dec", dp_decrement_entry, 0);
        tick();
        #1;
        check("mid_post2_inc", dp_increment_entry, 0);
        check("mid_post2_dec", dp_decrement_entry, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_bimodal_ctrl.md
Name: branch_bimodal_ctrl

Overview:
Control unit for the bimodal branch-predictor datapath (2-bit saturating-counter PHT with one PC port, increment/decrement controls and upper/lower-limit status). It shares the single datapath PC port between fetch-side prediction lookups and execute-side resolved-branch updates. Updates are buffered in a small FIFO. The unit generates the saturating increment/decrement controls and keeps a misprediction count. It sits between the fetch/execute stages and the predictor datapath.

Parameters:
QUEUE_DEPTH  4  update FIFO entries (power of 2, >=2)
STARVE_LIMIT  8  consecutive cycles an update may lose arbitration before it is forced (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
pred_req_val  in  1  prediction request valid
pred_req_rdy  out  1  prediction request ready
pred_req_pc  in  32  PC to predict
pred_resp_val  out  1  prediction response valid
pred_resp_rdy  in  1  prediction response ready
pred_resp_taken  out  1  predicted direction
upd_req_val  in  1  resolved-branch update valid
upd_req_rdy  out  1  update accepted (FIFO not full)
upd_req_pc  in  32  branch PC
upd_req_taken  in  1  actual direction
upd_req_pred  in  1  direction that was predicted
dp_pc  out  32  PC driven to datapath
dp_prediction  in  1  datapath prediction (counter MSB)
dp_upper_reached  in  1  indexed counter == 3
dp_lower_reached  in  1  indexed counter == 0
dp_increment_entry  out  1  increment indexed counter
dp_decrement_entry  out  1  decrement indexed counter
mispred_count  out  16  resolved mispredictions, saturating

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, resp register invalid, starvation counter = 0, mispred_count = 0. While reset is low, all handshake outputs and dp_increment_entry/dp_decrement_entry are 0. Reset mid-operation discards queued updates and any pending response.
- Datapath port is granted to exactly one operation per cycle: PRED, UPD or NONE.
- PRED is eligible when pred_req_val && resp slot free. The resp slot is free when !pred_resp_val, or when pred_resp_val && pred_resp_rdy (same-cycle drain and refill is allowed).
- UPD is eligible when the FIFO is non-empty.
- Arbitration:
  - PRED wins unless starve_cnt == STARVE_LIMIT, in which case UPD wins.
  - starve_cnt increments when UPD is eligible but loses; it resets to 0 when UPD is granted or the FIFO is empty.
- pred_req_rdy = PRED granted. On grant: dp_pc = pred_req_pc; dp_prediction is registered into pred_resp_taken; pred_resp_val goes to 1 the next cycle. Latency is 1 cycle. The response is held stable until pred_resp_rdy.
- UPD grant:
  - dp_pc = head.pc.
  - dp_increment_entry = head.taken && !dp_upper_reached.
  - dp_decrement_entry = !head.taken && !dp_lower_reached.
  - Never assert both. Pop the head. At most one update is applied per cycle.
- When neither is granted: dp_pc = head.pc if the FIFO is non-empty, else pred_req_pc; no inc/dec asserted.
- FIFO:
  - upd_req_rdy = !full. Enqueue {pc, taken} on val && rdy.
  - Simultaneous push and pop when full is not allowed: rdy is evaluated on the pre-pop state.
  - Push and pop in the same cycle when non-empty and not full are allowed; occupancy is unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- mispred_count increments by 1 on enqueue when upd_req_taken != upd_req_pred. It saturates at 16'hFFFF.
- Ordering: an update applied in cycle N is visible to a PRED granted in cycle N+1 or later. A same-cycle conflict cannot occur because only one grant is issued per cycle.

Test Plan:
- Reset hold: drive reset=0 for 3 cycles with all vals high -> all rdy/val/inc/dec = 0 and mispred_count = 0. After release, the FIFO is empty.
- Predict latency: with the datapath model counter = 2, pred_req_pc=0x100 valid in cycle 1 -> pred_resp_val=1 with pred_resp_taken=1 in cycle 2. With pred_resp_rdy=0 the response is held and pred_req_rdy=0 until drained.
- Saturation: enqueue 4 taken updates for PC 0x200 from counter 0 -> increments in 3 cycles, none on the 4th (upper reached). Then 4 not-taken updates -> counter reaches 0, and the 4th produces no decrement.
- Back-to-back predict throughput: pred_req_val and pred_resp_rdy held high for 10 cycles with an empty FIFO -> 10 responses in 10 consecutive cycles.
- Starvation: STARVE_LIMIT=8, continuous pred_req_val, one queued update -> the update is granted on cycle 9, and pred_req_rdy=0 in that cycle only.
- FIFO full / mispredict counting: push 5 updates with no grant possible, all with taken!=pred -> upd_req_rdy=0 on the 5th push and mispred_count=4. Then drain -> updates are applied in FIFO order and rdy returns to 1.
